branch_predictor: RTL and testbench

- Decode-stage branch predictor and push-side master of the branch queue (bq_push_if.master).
- Accepts decoded control-flow instructions, predicts direction and target with a 2-bit BHT and a JALR BTB, and redirects fetch.
- Pushes one bp_t per branch into the BQ and returns the allocated bqid to dispatch.
- Trains its tables from the commit-side BQ pop (bq_pop_if).

---
 rtl/branch_predictor_pkg.sv | 48 ++++
 rtl/branch_predictor_tables.sv | 70 +++++++
 rtl/branch_predictor.sv | 132 +++++++++++++
 tb/tb_branch_predictor.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and defaults for the decode-stage branch predictor.
//   id_t       : ROB sequence number
//   bq_id_t    : branch queue slot index (wraps modulo the queue depth)
//   ctrl_set_t : decoded control-flow operation
//   bp_t       : prediction / resolved outcome carried through the BQ
//   bht_ctr_t  : 2-bit saturating direction counter
package branch_predictor_pkg;

  localparam int NR_BHT_ENTRIES_DEF = 256;
  localparam int NR_BTB_ENTRIES_DEF = 64;
  localparam int ID_W   = 8;
  localparam int BQID_W = 3;

  typedef logic [ID_W-1:0]   id_t;
  typedef logic [BQID_W-1:0] bq_id_t;
  typedef logic [1:0]        bht_ctr_t;

  typedef enum logic [2:0] {
    CTRL_JAL  = 3'd0,
    CTRL_JALR = 3'd1,
    CTRL_BEQ  = 3'd2,
    CTRL_BNE  = 3'd3,
    CTRL_BLT  = 3'd4,
    CTRL_BGE  = 3'd5,
    CTRL_BLTU = 3'd6,
    CTRL_BGEU = 3'd7
  } ctrl_set_t;

  typedef struct packed {
    logic [63:0] pcnext;
    logic        taken;
  } bp_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } bp_state_t;

  function automatic logic is_cond(ctrl_set_t op);
    return !(op == CTRL_JAL || op == CTRL_JALR);
  endfunction

  function automatic bht_ctr_t bht_next(bht_ctr_t ctr, logic taken);
    if (taken) return (ctr == 2'b11) ? ctr : ctr + 2'b01;
    else       return (ctr == 2'b00) ? ctr : ctr - 2'b01;
  endfunction

endpackage

// File: rtl/branch_predictor_tables.sv
// BHT (2-bit counters, indexed by pc[k+1:2]) and direct-mapped JALR BTB.
// Ports:
//   rd_pc                       : lookup pc (combinational read of current state)
//   rd_ctr / rd_btb_hit / rd_btb_target : lookup results
//   train_valid/pc/op/bp        : commit-side training write port
// Reads see the pre-update value when lookup and training hit the same entry.
module branch_predictor_tables
  import branch_predictor_pkg::*;
#(
  parameter int NR_BHT_ENTRIES = NR_BHT_ENTRIES_DEF,
  parameter int NR_BTB_ENTRIES = NR_BTB_ENTRIES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] rd_pc,
  output bht_ctr_t    rd_ctr,
  output logic        rd_btb_hit,
  output logic [63:0] rd_btb_target,
  input  logic        train_valid,
  input  logic [63:0] train_pc,
  input  ctrl_set_t   train_op,
  input  bp_t         train_bp
);

  localparam int BHT_W = $clog2(NR_BHT_ENTRIES);
  localparam int BTB_W = $clog2(NR_BTB_ENTRIES);
  localparam int TAG_W = 64 - BTB_W - 2;

  bht_ctr_t          bht_q       [NR_BHT_ENTRIES];
  logic              btb_valid_q [NR_BTB_ENTRIES];
  logic [TAG_W-1:0]  btb_tag_q   [NR_BTB_ENTRIES];
  logic [63:0]       btb_tgt_q   [NR_BTB_ENTRIES];

  logic [BHT_W-1:0] rd_bht_idx, tr_bht_idx;
  logic [BTB_W-1:0] rd_btb_idx, tr_btb_idx;

  // Instructions are word aligned; the byte offset takes no part in indexing.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{rd_pc[1:0], train_pc[1:0]};

  assign rd_bht_idx = rd_pc[BHT_W+1:2];
  assign tr_bht_idx = train_pc[BHT_W+1:2];
  assign rd_btb_idx = rd_pc[BTB_W+1:2];
  assign tr_btb_idx = train_pc[BTB_W+1:2];

  assign rd_ctr        = bht_q[rd_bht_idx];
  assign rd_btb_hit    = btb_valid_q[rd_btb_idx] && (btb_tag_q[rd_btb_idx] == rd_pc[63:BTB_W+2]);
  assign rd_btb_target = btb_tgt_q[rd_btb_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NR_BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
      for (int i = 0; i < NR_BTB_ENTRIES; i++) btb_valid_q[i] <= 1'b0;
    end else if (train_valid) begin
      if (is_cond(train_op))
        bht_q[tr_bht_idx] <= bht_next(bht_q[tr_bht_idx], train_bp.taken);
      if (train_op == CTRL_JALR)
        btb_valid_q[tr_btb_idx] <= 1'b1;
    end
  end

  // Tag/target are qualified by the valid bit, so they need no reset.
  always_ff @(posedge clk) begin
    if (train_valid && train_op == CTRL_JALR) begin
      btb_tag_q[tr_btb_idx] <= train_pc[63:BTB_W+2];
      btb_tgt_q[tr_btb_idx] <= train_bp.pcnext;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Decode-stage branch predictor and push side of the branch queue.
// Predicts direction/target, redirects fetch, pushes one bp_t per branch
// into the BQ and hands the allocated bqid to dispatch. Trains on BQ pop.
// Ports: clk, rst (async, active-high), flush_i; dec_* decode handshake and
// instruction; redir_* fetch redirect; bq_push_* BQ push handshake/payload;
// disp_* bqid returned to dispatch; train_* committed branch outcome.
//
// state  | meaning
// S_IDLE | nothing held; ready for a new instruction
// S_HOLD | prediction registered, pushing it into the BQ
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int NR_BHT_ENTRIES = NR_BHT_ENTRIES_DEF,
  parameter int NR_BTB_ENTRIES = NR_BTB_ENTRIES_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic        dec_valid_i,
  output logic        dec_ready_o,
  input  logic [63:0] dec_pc_i,
  input  id_t         dec_id_i,
  input  logic [63:0] dec_imm_i,
  input  ctrl_set_t   dec_op_i,
  output logic        redir_valid_o,
  output logic [63:0] redir_pc_o,
  output logic        bq_push_valid_o,
  input  logic        bq_push_ready_i,
  input  bq_id_t      bq_push_bqid_i,
  output logic [63:0] bq_push_pc_o,
  output id_t         bq_push_id_o,
  output bp_t         bq_push_bp_o,
  output logic        disp_bqid_valid_o,
  output bq_id_t      disp_bqid_o,
  output id_t         disp_id_o,
  input  logic        train_valid_i,
  input  logic [63:0] train_pc_i,
  input  ctrl_set_t   train_op_i,
  input  bp_t         train_bp_i
);

  bp_state_t   state_q, state_d;
  logic [63:0] pc_q;
  id_t         id_q;
  bp_t         bp_q;
  logic        redir_q;
  logic        accept, push_done;

  bht_ctr_t    rd_ctr;
  logic        btb_hit;
  logic [63:0] btb_target;
  bp_t         pred;

  branch_predictor_tables #(
    .NR_BHT_ENTRIES(NR_BHT_ENTRIES),
    .NR_BTB_ENTRIES(NR_BTB_ENTRIES)
  ) u_tables (
    .clk          (clk),
    .rst          (rst),
    .rd_pc        (dec_pc_i),
    .rd_ctr       (rd_ctr),
    .rd_btb_hit   (btb_hit),
    .rd_btb_target(btb_target),
    .train_valid  (train_valid_i),
    .train_pc     (train_pc_i),
    .train_op     (train_op_i),
    .train_bp     (train_bp_i)
  );

  always_comb begin
    pred = '0;
    case (dec_op_i)
      CTRL_JAL: begin
        pred.taken  = 1'b1;
        pred.pcnext = dec_pc_i + dec_imm_i;
      end
      CTRL_JALR: begin
        // The BQ compares JALR targets with bit 0 cleared.
        pred.taken  = btb_hit;
        pred.pcnext = (btb_hit ? btb_target : dec_pc_i + 64'd4) & ~64'd1;
      end
      default: begin
        pred.taken  = rd_ctr[1];
        pred.pcnext = rd_ctr[1] ? dec_pc_i + dec_imm_i : dec_pc_i + 64'd4;
      end
    endcase
  end

  always_comb begin
    state_d           = state_q;
    dec_ready_o       = (state_q == S_IDLE) ? 1'b1 : bq_push_ready_i;
    accept            = dec_valid_i && dec_ready_o && !flush_i;
    push_done         = (state_q == S_HOLD) && bq_push_ready_i;
    bq_push_valid_o   = (state_q == S_HOLD);
    disp_bqid_valid_o = push_done;
    if (flush_i)        state_d = S_IDLE;
    else if (accept)    state_d = S_HOLD;
    else if (push_done) state_d = S_IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      redir_q <= 1'b0;
      pc_q    <= '0;
      id_q    <= '0;
      bp_q    <= '0;
    end else begin
      state_q <= state_d;
      redir_q <= accept && pred.taken;
      if (accept) begin
        pc_q <= dec_pc_i;
        id_q <= dec_id_i;
        bp_q <= pred;
      end
    end
  end

  // A flush in the pulse cycle cancels the redirect of the entry being dropped.
  assign redir_valid_o = redir_q && !flush_i;
  assign redir_pc_o    = bp_q.pcnext;
  assign bq_push_pc_o  = pc_q;
  assign bq_push_id_o  = id_q;
  assign bq_push_bp_o  = bp_q;
  assign disp_bqid_o   = bq_push_bqid_i;
  assign disp_id_o     = id_q;

  a_payload_stable: assert property (@(posedge clk) disable iff (rst)
    (bq_push_valid_o && !bq_push_ready_i) |=> $stable({pc_q, id_q, bp_q}));

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;
  import branch_predictor_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        dec_valid_i = 1'b0;
  logic        dec_ready_o;
  logic [63:0] dec_pc_i = '0;
  id_t         dec_id_i = '0;
  logic [63:0] dec_imm_i = '0;
  ctrl_set_t   dec_op_i = CTRL_JAL;
  logic        redir_valid_o;
  logic [63:0] redir_pc_o;
  logic        bq_push_valid_o;
  logic        bq_push_ready_i = 1'b1;
  bq_id_t      bq_push_bqid_i;
  logic [63:0] bq_push_pc_o;
  id_t         bq_push_id_o;
  bp_t         bq_push_bp_o;
  logic        disp_bqid_valid_o;
  bq_id_t      disp_bqid_o;
  id_t         disp_id_o;
  logic        train_valid_i = 1'b0;
  logic [63:0] train_pc_i = '0;
  ctrl_set_t   train_op_i = CTRL_JAL;
  bp_t         train_bp_i = '0;

  branch_predictor dut (
    .clk(clk), .rst(rst), .flush_i(flush_i),
    .dec_valid_i(dec_valid_i), .dec_ready_o(dec_ready_o), .dec_pc_i(dec_pc_i),
    .dec_id_i(dec_id_i), .dec_imm_i(dec_imm_i), .dec_op_i(dec_op_i),
    .redir_valid_o(redir_valid_o), .redir_pc_o(redir_pc_o),
    .bq_push_valid_o(bq_push_valid_o), .bq_push_ready_i(bq_push_ready_i),
    .bq_push_bqid_i(bq_push_bqid_i), .bq_push_pc_o(bq_push_pc_o),
    .bq_push_id_o(bq_push_id_o), .bq_push_bp_o(bq_push_bp_o),
    .disp_bqid_valid_o(disp_bqid_valid_o), .disp_bqid_o(disp_bqid_o),
    .disp_id_o(disp_id_o), .train_valid_i(train_valid_i), .train_pc_i(train_pc_i),
    .train_op_i(train_op_i), .train_bp_i(train_bp_i)
  );

  always #5 clk = ~clk;

  // Branch queue tail: the slot offered to the current push, advancing per handshake.
  bq_id_t bq_tail;
  always @(posedge clk or posedge rst)
    if (rst) bq_tail <= '0;
    else if (bq_push_valid_o && bq_push_ready_i) bq_tail <= bq_tail + 1'b1;
  assign bq_push_bqid_i = bq_tail;

  int n_pass = 0;
  int n_total = 0;
  int exp_bqid = 0;

  task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Reference model: counters as integers 0..3, BTB as per-slot records.
  int          m_bht [256];
  bit          m_btb_v [64];
  logic [55:0] m_btb_tag [64];
  logic [63:0] m_btb_tgt [64];

  function automatic void m_predict(ctrl_set_t op, logic [63:0] pc, logic [63:0] imm,
                                    output logic taken, output logic [63:0] pcnext);
    int bi, ti;
    bi = int'(pc[9:2]);
    ti = int'(pc[7:2]);
    if (op == CTRL_JAL) begin
      taken = 1; pcnext = pc + imm;
    end else if (op == CTRL_JALR) begin
      taken = m_btb_v[ti] && m_btb_tag[ti] == pc[63:8];
      pcnext = taken ? {m_btb_tgt[ti][63:1], 1'b0} : pc + 4;
    end else begin
      taken = m_bht[bi] >= 2;
      pcnext = taken ? pc + imm : pc + 4;
    end
  endfunction

  function automatic void m_train(ctrl_set_t op, logic [63:0] pc, logic taken, logic [63:0] pcnext);
    int bi, ti;
    bi = int'(pc[9:2]);
    ti = int'(pc[7:2]);
    if (op == CTRL_JALR) begin
      m_btb_v[ti] = 1; m_btb_tag[ti] = pc[63:8]; m_btb_tgt[ti] = pcnext;
    end else if (op != CTRL_JAL) begin
      if (taken && m_bht[bi] < 3) m_bht[bi]++;
      if (!taken && m_bht[bi] > 0) m_bht[bi]--;
    end
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Issue one instruction (BQ ready) and check the push one cycle later.
  // Any training already driven by the caller is applied in the issue cycle.
  task automatic issue(ctrl_set_t op, logic [63:0] pc, logic [63:0] imm, id_t id,
                       logic et, logic [63:0] ep);
    dec_valid_i = 1; dec_op_i = op; dec_pc_i = pc; dec_imm_i = imm; dec_id_i = id;
    #1; chk("dec_ready_idle", dec_ready_o, 1);
    @(posedge clk); #1;
    dec_valid_i = 0; train_valid_i = 0;
    #1;
    chk("push_valid", bq_push_valid_o, 1);
    chk("push_pc", bq_push_pc_o, pc);
    chk("push_id", bq_push_id_o, id);
    chk("push_taken", bq_push_bp_o.taken, et);
    chk("push_pcnext", bq_push_bp_o.pcnext, ep);
    chk("redir_valid", redir_valid_o, et);
    if (et) chk("redir_pc", redir_pc_o, ep);
    chk("disp_valid", disp_bqid_valid_o, 1);
    chk("disp_bqid", disp_bqid_o, exp_bqid[BQID_W-1:0]);
    chk("disp_id", disp_id_o, id);
    exp_bqid++;
    step();
  endtask

  task automatic train(ctrl_set_t op, logic [63:0] pc, logic taken, logic [63:0] pcnext);
    train_valid_i = 1; train_op_i = op; train_pc_i = pc;
    train_bp_i.taken = taken; train_bp_i.pcnext = pcnext;
    m_train(op, pc, taken, pcnext);
    step();
    train_valid_i = 0;
  endtask

  typedef struct {
    ctrl_set_t   op;
    logic [63:0] pc;
    logic [63:0] imm;
    logic        exp_taken;
    logic [63:0] exp_pcnext;
  } vec_t;

  vec_t vecs[7];

  logic [63:0] pool [5];
  logic        et;
  logic [63:0] ep;

  initial begin
    for (int i = 0; i < 256; i++) m_bht[i] = 1;
    for (int i = 0; i < 64; i++) m_btb_v[i] = 0;

    vecs[0] = '{CTRL_BEQ,  64'h1000, 64'h40, 1'b0, 64'h1004};
    vecs[1] = '{CTRL_BNE,  64'h1100, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 64'h1104};
    vecs[2] = '{CTRL_JAL,  64'h1200, 64'h100, 1'b1, 64'h1300};
    vecs[3] = '{CTRL_JAL,  64'hFFFF_FFFF_FFFF_FFF0, 64'h20, 1'b1, 64'h10};
    vecs[4] = '{CTRL_JAL,  64'h4000, 64'hFFFF_FFFF_FFFF_F000, 1'b1, 64'h3000};
    vecs[5] = '{CTRL_JALR, 64'h2000, 64'h0, 1'b0, 64'h2004};
    vecs[6] = '{CTRL_BGEU, 64'h1FFC, 64'h10, 1'b0, 64'h2000};

    #2;
    chk("rst_dec_ready", dec_ready_o, 1);
    chk("rst_push_valid", bq_push_valid_o, 0);
    chk("rst_redir_valid", redir_valid_o, 0);
    chk("rst_disp_valid", disp_bqid_valid_o, 0);
    step(); step();
    rst = 0;
    step();

    // Fresh tables: table-driven predictions.
    for (int i = 0; i < 7; i++)
      issue(vecs[i].op, vecs[i].pc, vecs[i].imm, id_t'(i + 1), vecs[i].exp_taken, vecs[i].exp_pcnext);

    // BHT training: two taken trains flip the prediction.
    train(CTRL_BEQ, 64'h1000, 1, 64'h1040);
    train(CTRL_BEQ, 64'h1000, 1, 64'h1040);
    issue(CTRL_BEQ, 64'h1000, 64'h40, 8'h10, 1'b1, 64'h1040);
    // Saturation: a third taken then one not-taken must still predict taken.
    train(CTRL_BEQ, 64'h1000, 1, 64'h1040);
    train(CTRL_BEQ, 64'h1000, 0, 64'h1004);
    issue(CTRL_BEQ, 64'h1000, 64'h40, 8'h11, 1'b1, 64'h1040);
    // Two more not-taken reach 00; one more must stay at 00.
    train(CTRL_BEQ, 64'h1000, 0, 64'h1004);
    train(CTRL_BEQ, 64'h1000, 0, 64'h1004);
    train(CTRL_BEQ, 64'h1000, 0, 64'h1004);
    train(CTRL_BEQ, 64'h1000, 1, 64'h1040);
    issue(CTRL_BEQ, 64'h1000, 64'h40, 8'h12, 1'b0, 64'h1004);

    // JALR: miss then trained hit with bit 0 cleared.
    issue(CTRL_JALR, 64'h2000, 64'h0, 8'h20, 1'b0, 64'h2004);
    train(CTRL_JALR, 64'h2000, 1, 64'h3001);
    issue(CTRL_JALR, 64'h2000, 64'h0, 8'h21, 1'b1, 64'h3000);
    // Same index, different tag: miss.
    issue(CTRL_JALR, 64'h2100, 64'h0, 8'h22, 1'b0, 64'h2104);

    // Backpressure with back-to-back decodes.
    bq_push_ready_i = 0;
    dec_valid_i = 1; dec_op_i = CTRL_JAL; dec_pc_i = 64'h6000; dec_imm_i = 64'h80; dec_id_i = 8'h30;
    step();
    dec_pc_i = 64'h6100; dec_imm_i = 64'h8; dec_id_i = 8'h31;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_dec_ready", dec_ready_o, 0);
      chk("bp_push_valid", bq_push_valid_o, 1);
      chk("bp_push_pc", bq_push_pc_o, 64'h6000);
      chk("bp_push_pcnext", bq_push_bp_o.pcnext, 64'h6080);
      chk("bp_disp_valid", disp_bqid_valid_o, 0);
      chk("bp_redir", redir_valid_o, c == 0);
      step();
    end
    bq_push_ready_i = 1;
    #1;
    chk("bp_rel_ready", dec_ready_o, 1);
    chk("bp_rel_disp_valid", disp_bqid_valid_o, 1);
    chk("bp_rel_bqid", disp_bqid_o, exp_bqid[BQID_W-1:0]);
    chk("bp_rel_id", disp_id_o, 8'h30);
    exp_bqid++;
    step();
    dec_valid_i = 0;
    #1;
    chk("bp_b_valid", bq_push_valid_o, 1);
    chk("bp_b_pc", bq_push_pc_o, 64'h6100);
    chk("bp_b_pcnext", bq_push_bp_o.pcnext, 64'h6108);
    chk("bp_b_redir", redir_valid_o, 1);
    chk("bp_b_bqid", disp_bqid_o, exp_bqid[BQID_W-1:0]);
    chk("bp_b_id", disp_id_o, 8'h31);
    exp_bqid++;
    step();
    #1; chk("bp_idle", bq_push_valid_o, 0);

    // Flush in the same cycle as decode: nothing accepted.
    dec_valid_i = 1; flush_i = 1; dec_op_i = CTRL_JAL; dec_pc_i = 64'h7000; dec_id_i = 8'h40;
    step();
    dec_valid_i = 0; flush_i = 0;
    #1;
    chk("fl_same_push", bq_push_valid_o, 0);
    chk("fl_same_redir", redir_valid_o, 0);
    chk("fl_same_ready", dec_ready_o, 1);

    // Flush while holding (BQ full); training in the flush cycle still applies.
    bq_push_ready_i = 0;
    dec_valid_i = 1; dec_op_i = CTRL_JAL; dec_pc_i = 64'h7100; dec_imm_i = 64'h10; dec_id_i = 8'h41;
    step();
    dec_valid_i = 0;
    flush_i = 1;
    train_valid_i = 1; train_op_i = CTRL_BEQ; train_pc_i = 64'h5010;
    train_bp_i.taken = 1; train_bp_i.pcnext = 64'h5030;
    m_train(CTRL_BEQ, 64'h5010, 1, 64'h5030);
    #1;
    chk("fl_hold_redir", redir_valid_o, 0);
    chk("fl_hold_disp", disp_bqid_valid_o, 0);
    step();
    flush_i = 0; train_valid_i = 0; bq_push_ready_i = 1;
    #1;
    chk("fl_hold_push", bq_push_valid_o, 0);
    chk("fl_hold_ready", dec_ready_o, 1);
    step();
    issue(CTRL_BEQ, 64'h5010, 64'h20, 8'h42, 1'b1, 64'h5030);

    // Back-to-back stream across the bqid wrap.
    for (int i = 0; i <= 9; i++) begin
      dec_valid_i = (i < 9);
      dec_op_i = CTRL_BEQ; dec_pc_i = 64'h8000 + 64'(4 * i); dec_imm_i = 64'h40; dec_id_i = id_t'(8'h50 + i);
      #1;
      chk("wr_ready", dec_ready_o, 1);
      if (i > 0) begin
        chk("wr_disp_valid", disp_bqid_valid_o, 1);
        chk("wr_bqid", disp_bqid_o, exp_bqid[BQID_W-1:0]);
        chk("wr_id", disp_id_o, 8'h50 + i - 1);
        exp_bqid++;
      end
      step();
    end
    #1; chk("wr_idle", bq_push_valid_o, 0);

    // Random issue with same-cycle training against the model.
    pool[0] = 64'h1000; pool[1] = 64'h1400; pool[2] = 64'h2000;
    pool[3] = 64'h2100; pool[4] = 64'h3008;
    for (int it = 0; it < 200; it++) begin
      ctrl_set_t op, top;
      logic [63:0] pc, imm, tpc, tnext;
      logic tt;
      op  = ctrl_set_t'($urandom_range(0, 7));
      pc  = pool[$urandom_range(0, 4)];
      imm = 64'($signed($urandom_range(0, 1023) * 4 - 2048));
      m_predict(op, pc, imm, et, ep);
      if ($urandom_range(0, 1) == 1) begin
        top = ctrl_set_t'($urandom_range(0, 7));
        tpc = pool[$urandom_range(0, 4)];
        tt = 1'($urandom_range(0, 1));
        tnext = {48'h0, 16'($urandom)};
        train_valid_i = 1; train_op_i = top; train_pc_i = tpc;
        train_bp_i.taken = tt; train_bp_i.pcnext = tnext;
        m_train(top, tpc, tt, tnext);
      end
      issue(op, pc, imm, id_t'(it), et, ep);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
